// File: rtl/am29xx_sequencer_if.sv
// Bus interface of the microprogram sequencer: control, address inputs and optional stack flags.
// Optional feature macro: AM29XX_STACK_FLAGS_EN adds the FULL/EMPTY stack flags.
interface am29xx_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             FE;
  logic             PUP;
  logic             RE;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] R;
  logic [1:0]       S;
  logic             OE;
  logic [WIDTH-1:0] OR;
  logic             ZERO;
  logic             C;
`ifdef AM29XX_STACK_FLAGS_EN
  logic             FULL;
  logic             EMPTY;

  modport master (output FE, PUP, RE, D, R, S, OE, OR, ZERO, C, input FULL, EMPTY);
  modport slave  (input FE, PUP, RE, D, R, S, OE, OR, ZERO, C, output FULL, EMPTY);
`else
  modport master (output FE, PUP, RE, D, R, S, OE, OR, ZERO, C);
  modport slave  (input FE, PUP, RE, D, R, S, OE, OR, ZERO, C);
`endif
endinterface

// File: rtl/am29xx_sequencer.sv
// Parametrised microprogram sequencer: next-address mux, OR/ZERO forcing, carry-in
// incrementer, address register and a push/pop subroutine stack of DEPTH entries.
// Optional feature macro: AM29XX_STACK_FLAGS_EN (occupancy count, FULL/EMPTY, guarded ops).
module am29xx_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CP,
  input  logic             RST,
  am29xx_sequencer_if.slave bus,
  output wire  [WIDTH-1:0] Y
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef AM29XX_STACK_FLAGS_EN
  localparam int unsigned CW = $clog2(DEPTH + 1);
`endif

  logic [WIDTH-1:0] upc_q, upc_d;
  logic [WIDTH-1:0] ar_q, ar_d;
  logic [PW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] file_q [DEPTH];
  logic [WIDTH-1:0] file_d [DEPTH];
`ifdef AM29XX_STACK_FLAGS_EN
  logic [CW-1:0]    count_q, count_d;
`endif

  logic [WIDTH-1:0] mux_c;
  logic [WIDTH-1:0] addr_c;
  logic             push_c;
  logic             pop_c;

  // Next-address source select from pre-edge state
  always_comb begin
    mux_c = upc_q;
    unique case (bus.S)
      2'b00:   mux_c = upc_q;
      2'b01:   mux_c = ar_q;
      2'b10:   mux_c = file_q[sp_q];
      default: mux_c = bus.D;
    endcase
  end

  assign addr_c = (!bus.ZERO) ? '0 : (mux_c | bus.OR);
  assign Y      = (!bus.OE) ? addr_c : {WIDTH{1'bz}};

  // Stack operation qualification; with flags, overflow/underflow ops are dropped
  always_comb begin
    push_c = !bus.FE && bus.PUP;
    pop_c  = !bus.FE && !bus.PUP;
`ifdef AM29XX_STACK_FLAGS_EN
    if (count_q == CW'(DEPTH)) push_c = 1'b0;
    if (count_q == '0)         pop_c  = 1'b0;
`endif
  end

  // Next-state for uPC, AR, stack pointer and stack file
  always_comb begin
    upc_d  = addr_c + WIDTH'(bus.C);
    ar_d   = (!bus.RE) ? bus.R : ar_q;
    sp_d   = sp_q;
    file_d = file_q;
`ifdef AM29XX_STACK_FLAGS_EN
    count_d = count_q;
`endif
    if (push_c) begin
      sp_d         = sp_q + PW'(1);
      file_d[sp_d] = upc_q;
`ifdef AM29XX_STACK_FLAGS_EN
      count_d      = count_q + CW'(1);
`endif
    end else if (pop_c) begin
      sp_d         = sp_q - PW'(1);
`ifdef AM29XX_STACK_FLAGS_EN
      count_d      = count_q - CW'(1);
`endif
    end
  end

  // State registers with asynchronous clear of every entry
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      upc_q <= '0;
      ar_q  <= '0;
      sp_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) file_q[i] <= '0;
`ifdef AM29XX_STACK_FLAGS_EN
      count_q <= '0;
`endif
    end else begin
      upc_q <= upc_d;
      ar_q  <= ar_d;
      sp_q  <= sp_d;
      for (int i = 0; i < int'(DEPTH); i++) file_q[i] <= file_d[i];
`ifdef AM29XX_STACK_FLAGS_EN
      count_q <= count_d;
`endif
    end
  end

`ifdef AM29XX_STACK_FLAGS_EN
  assign bus.EMPTY = (count_q == '0);
  assign bus.FULL  = (count_q == CW'(DEPTH));
`endif

endmodule
